program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port extRst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port inData, input, 8, byte offered by the host byte stream.
REQ-004 SHALL have port inValid, input, 1, inData holds a valid byte.
REQ-005 SHALL have port inReady, output, 1, loader accepts a byte this cycle.
REQ-006 SHALL have port reload, input, 1, request to reload the program; sampled on clk.
REQ-007 SHALL have port memAddr, input, 8, fetch address from the CPU program counter.
REQ-008 SHALL have port memVal, output, 8, program byte returned to the CPU control unit.
REQ-009 SHALL have port cpuRst, output, 1, drives the CPU extRst input; high holds the CPU in reset.
REQ-010 SHALL have port busy, output, 1, high in every state except RUN.

Function
REQ-011 SHALL contain a 256 x 8 program RAM, write pointer wrPtr[7:0] and remaining-count cnt[8:0].
REQ-012 SHALL transfer a byte only on a rising edge with inValid=1 and inReady=1.
REQ-013 SHALL drive inReady=1 only in states WAIT_LEN and LOAD, independent of inValid.
REQ-014 SHALL implement states CLEAR, WAIT_LEN, LOAD, RELEASE and RUN.
REQ-015 CLEAR: write 0x00 to RAM[wrPtr] each cycle, increment wrPtr; after writing address 255, set wrPtr=0 and go to WAIT_LEN; duration 256 cycles.
REQ-016 WAIT_LEN: on transfer, set cnt=inData, or 256 when inData=0x00; go to LOAD; wrPtr=0.
REQ-017 LOAD: on transfer, write inData to RAM[wrPtr], increment wrPtr (mod 256), decrement cnt; on the transfer that makes cnt=0, go to RELEASE.
REQ-018 LOAD: cycles without a transfer SHALL hold all state; there is no timeout.
REQ-019 RELEASE: lasts exactly one cycle with cpuRst=1, then go to RUN.
REQ-020 RUN: drive cpuRst=0; memVal SHALL equal RAM[memAddr] combinationally (zero-cycle read latency).
REQ-021 In every state other than RUN, memVal SHALL be 0x00 and cpuRst SHALL be 1.
REQ-022 reload=1 on a rising edge in RUN SHALL go to CLEAR with wrPtr=0; cpuRst rises in the same cycle as the state change.
REQ-023 reload SHALL be ignored in CLEAR, WAIT_LEN, LOAD and RELEASE.
REQ-024 A length of 256 SHALL fill every RAM location; the final write to address 255 SHALL NOT be lost on wrPtr wrap.
REQ-025 Bytes not written during LOAD SHALL read 0x00 in RUN, because CLEAR precedes every load.
REQ-026 All outputs SHALL be registered, or decoded from registered state only, except memVal in RUN (REQ-020).

Reset
REQ-027 extRst=1 SHALL immediately force state=CLEAR, wrPtr=0, cnt=0, cpuRst=1, busy=1, inReady=0 and memVal=0x00, without waiting for clk.
REQ-028 Reset asserted mid-LOAD or mid-RUN SHALL discard the partial program; the next load starts with a full CLEAR.
REQ-029 After extRst falls, CLEAR SHALL begin on the first rising clk edge.
REQ-030 RAM contents SHALL NOT need a reset value; CLEAR defines them.

Verification
REQ-031 Basic load: reset, wait 256 cycles, send 0x03, 0xA1, 0xB2, 0xC3 -> RELEASE for 1 cycle, then cpuRst=0; memAddr=0,1,2,3 gives memVal=A1, B2, C3, 00.
REQ-032 Backpressure: assert inValid during CLEAR -> inReady=0 and no byte is consumed; the first byte accepted is the one still held in the first WAIT_LEN cycle.
REQ-033 Full program: send length 0x00, then 256 bytes with value equal to the index -> memVal==memAddr for all 256 addresses; wrPtr wraps to 0.
REQ-034 Gapped stream: send length 0x02, then bytes with 5 idle cycles between them -> state stays LOAD during the gaps; the contents are correct.
REQ-035 Reload: in RUN, pulse reload for 1 cycle -> cpuRst=1 on the next edge, 256-cycle CLEAR, then load 0x01, 0x7E -> RAM[0]=7E and RAM[1]=00.
REQ-036 Mid-load reset: assert extRst asynchronously between clock edges after 2 of 5 data bytes -> cpuRst=1 and inReady=0 at once; after release, CLEAR lasts 256 cycles and the old bytes read 0x00.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: clears a 256-byte program RAM, loads a length-prefixed
// byte stream into it, then releases the CPU to fetch from it.
module program_loader (
  input  logic       clk,
  input  logic       extRst,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       inReady,
  input  logic       reload,
  input  logic [7:0] memAddr,
  output logic [7:0] memVal,
  output logic       cpuRst,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT_LEN,
    S_LOAD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t     r_state, w_state_nx;
  logic [7:0] r_wrPtr, w_wrPtr_nx;
  logic [8:0] r_cnt, w_cnt_nx;
  logic [7:0] r_mem [256];
  logic       w_we;
  logic [7:0] w_wdata;
  logic       w_xfer;

  assign inReady = (r_state == S_WAIT_LEN) || (r_state == S_LOAD);
  assign busy    = (r_state != S_RUN);
  assign cpuRst  = (r_state != S_RUN);
  assign memVal  = (r_state == S_RUN) ? r_mem[memAddr] : 8'h00;
  assign w_xfer  = inValid && inReady;

  always_ff @(posedge clk or posedge extRst) begin
    if (extRst) begin
      r_state <= S_CLEAR;
      r_wrPtr <= 8'd0;
      r_cnt   <= 9'd0;
    end else begin
      r_state <= w_state_nx;
      r_wrPtr <= w_wrPtr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // RAM has no reset; CLEAR defines its contents
  always_ff @(posedge clk) begin
    if (w_we && !extRst)
      r_mem[r_wrPtr] <= w_wdata;
  end

  always_comb begin
    w_state_nx = r_state;
    w_wrPtr_nx = r_wrPtr;
    w_cnt_nx   = r_cnt;
    w_we       = 1'b0;
    w_wdata    = 8'h00;
    unique case (r_state)
      S_CLEAR: begin
        w_we       = 1'b1;
        w_wrPtr_nx = r_wrPtr + 8'd1;
        if (r_wrPtr == 8'hFF)
          w_state_nx = S_WAIT_LEN;
      end
      S_WAIT_LEN: begin
        if (w_xfer) begin
          w_cnt_nx   = (inData == 8'h00) ? 9'd256 : {1'b0, inData};
          w_wrPtr_nx = 8'd0;
          w_state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_we       = 1'b1;
          w_wdata    = inData;
          w_wrPtr_nx = r_wrPtr + 8'd1;
          w_cnt_nx   = r_cnt - 9'd1;
          if (r_cnt == 9'd1)
            w_state_nx = S_RELEASE;
        end
      end
      S_RELEASE: w_state_nx = S_RUN;
      S_RUN: begin
        if (reload) begin
          w_wrPtr_nx = 8'd0;
          w_state_nx = S_CLEAR;
        end
      end
      default: w_state_nx = S_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a byte-array reference
// model of the program RAM.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       extRst;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic       reload;
  logic [7:0] memAddr;
  logic [7:0] memVal;
  logic       cpuRst;
  logic       busy;

  int passed = 0;
  int total  = 0;
  logic [7:0] mdl [256];

  program_loader dut (
    .clk(clk), .extRst(extRst), .inData(inData), .inValid(inValid),
    .inReady(inReady), .reload(reload), .memAddr(memAddr),
    .memVal(memVal), .cpuRst(cpuRst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
  endtask

  task automatic hold_reset;
    extRst  = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;
    reload  = 1'b0;
    memAddr = 8'h00;
    model_clear();
    repeat (2) @(negedge clk);
    extRst = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (inReady) break;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    inValid = 1'b1;
    inData  = b;
    while (!inReady && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      total++;
      $display("FAIL send_byte_timeout: inReady=%0b required 1", inReady);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] len, input logic [7:0] d[$]);
    send_byte(len);
    foreach (d[i]) begin
      send_byte(d[i]);
      mdl[i % 256] = d[i];
    end
  endtask

  task automatic test_reset;
    int n;
    extRst  = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;
    reload  = 1'b0;
    memAddr = 8'h00;
    #1;
    total++;
    if (cpuRst !== 1'b1) $display("FAIL rst_cpuRst: got %b want 1", cpuRst);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy);
    else passed++;
    total++;
    if (inReady !== 1'b0) $display("FAIL rst_inReady: got %b want 0", inReady);
    else passed++;
    total++;
    if (memVal !== 8'h00) $display("FAIL rst_memVal: got %h want 00", memVal);
    else passed++;
    model_clear();
    repeat (2) @(negedge clk);
    extRst = 1'b0;
    count_clear(n);
    total++;
    if (n !== 256) $display("FAIL rst_clear_len: got %0d want 256", n);
    else passed++;
  endtask

  task automatic test_basic_load;
    logic [7:0] d[$];
    logic [7:0] exp4 [4];
    d = '{8'hA1, 8'hB2, 8'hC3};
    exp4 = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
    load_prog(8'h03, d);
    total++;
    if (cpuRst !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_release: cpuRst=%b busy=%b want 1 1", cpuRst, busy);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (cpuRst !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_run: cpuRst=%b busy=%b want 0 0", cpuRst, busy);
    else passed++;
    for (int a = 0; a < 4; a++) begin
      memAddr = a[7:0];
      #1;
      total++;
      if (memVal !== exp4[a])
        $display("FAIL basic_mem[%0d]: got %h want %h", a, memVal, exp4[a]);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [7:0] b0, b1;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    extRst  = 1'b1;
    reload  = 1'b0;
    model_clear();
    @(negedge clk);
    inValid = 1'b1;
    inData  = 8'h02;
    @(negedge clk);
    extRst = 1'b0;
    count_clear(n);
    total++;
    if (n !== 256) $display("FAIL bp_clear_len: got %0d want 256", n);
    else passed++;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    total++;
    if (inReady !== 1'b1 || busy !== 1'b1)
      $display("FAIL bp_in_load: inReady=%b busy=%b want 1 1", inReady, busy);
    else passed++;
    send_byte(b0);
    send_byte(b1);
    mdl[0] = b0;
    mdl[1] = b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL bp_run: busy=%b want 0", busy);
    else passed++;
    for (int a = 0; a < 4; a++) begin
      memAddr = a[7:0];
      #1;
      total++;
      if (memVal !== mdl[a])
        $display("FAIL bp_mem[%0d]: got %h want %h", a, memVal, mdl[a]);
      else passed++;
    end
  endtask

  task automatic test_full_program;
    int n;
    logic [7:0] d[$];
    hold_reset();
    count_clear(n);
    for (int i = 0; i < 256; i++) d.push_back(i[7:0]);
    load_prog(8'h00, d);
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL full_run: busy=%b want 0", busy);
    else passed++;
    for (int a = 0; a < 256; a++) begin
      memAddr = a[7:0];
      #1;
      total++;
      if (memVal !== mdl[a])
        $display("FAIL full_mem[%0d]: got %h want %h", a, memVal, mdl[a]);
      else passed++;
    end
  endtask

  task automatic test_gapped;
    int n;
    logic [7:0] b0, b1;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    hold_reset();
    count_clear(n);
    send_byte(8'h02);
    send_byte(b0);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      reload = (g == 2);
      total++;
      if (inReady !== 1'b1 || busy !== 1'b1)
        $display("FAIL gap_hold[%0d]: inReady=%b busy=%b want 1 1",
                 g, inReady, busy);
      else passed++;
    end
    @(negedge clk);
    reload = 1'b0;
    send_byte(b1);
    mdl[0] = b0;
    mdl[1] = b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 256; a++) begin
      memAddr = a[7:0];
      #1;
      total++;
      if (memVal !== mdl[a])
        $display("FAIL gap_mem[%0d]: got %h want %h", a, memVal, mdl[a]);
      else passed++;
    end
  endtask

  task automatic test_reload;
    int n;
    logic [7:0] d[$];
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    total++;
    if (cpuRst !== 1'b1 || inReady !== 1'b0)
      $display("FAIL reload_rst: cpuRst=%b inReady=%b want 1 0",
               cpuRst, inReady);
    else passed++;
    model_clear();
    count_clear(n);
    total++;
    if (n !== 256) $display("FAIL reload_clear_len: got %0d want 256", n);
    else passed++;
    d = '{8'h7E};
    load_prog(8'h01, d);
    @(posedge clk);
    #1;
    for (int a = 0; a < 256; a++) begin
      memAddr = a[7:0];
      #1;
      total++;
      if (memVal !== mdl[a])
        $display("FAIL reload_mem[%0d]: got %h want %h", a, memVal, mdl[a]);
      else passed++;
    end
  endtask

  task automatic test_midload_reset;
    int n;
    logic [7:0] d[$];
    hold_reset();
    count_clear(n);
    send_byte(8'h05);
    send_byte(8'($urandom_range(1, 255)));
    send_byte(8'($urandom_range(1, 255)));
    @(posedge clk);
    #3;
    extRst = 1'b1;
    #1;
    total++;
    if (cpuRst !== 1'b1 || inReady !== 1'b0 || busy !== 1'b1)
      $display("FAIL mid_rst: cpuRst=%b inReady=%b busy=%b want 1 0 1",
               cpuRst, inReady, busy);
    else passed++;
    model_clear();
    @(negedge clk);
    extRst = 1'b0;
    count_clear(n);
    total++;
    if (n !== 256) $display("FAIL mid_clear_len: got %0d want 256", n);
    else passed++;
    d = '{8'($urandom_range(0, 255))};
    load_prog(8'h01, d);
    @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      memAddr = a[7:0];
      #1;
      total++;
      if (memVal !== mdl[a])
        $display("FAIL mid_mem[%0d]: got %h want %h", a, memVal, mdl[a]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_full_program();
    test_gapped();
    test_reload();
    test_midload_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
